// File: rtl/distram_fifo_pkg.sv
// Shared constants for the distributed-RAM FIFO family.
// Legal depth range and the address width of one LUT-RAM primitive.
package distram_fifo_pkg;

    localparam int DEPTH_LOG2_MIN = 2;
    localparam int DEPTH_LOG2_MAX = 8;
    localparam int PRIM_ADDR_BITS = 6;

endpackage

// File: rtl/distram_sdp.sv
// Simple-dual-port distributed RAM: synchronous write, asynchronous read.
// Small depths map bitwise onto 64x1 LUT-RAM cells; larger depths are inferred.
import distram_fifo_pkg::*;

// Behavioural 64x1 dual-port LUT-RAM cell, read-port subset of the vendor RAM64X1D.
module RAM64X1D (
    input  logic WCLK,
    input  logic WE,
    input  logic D,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic DPRA0,
    input  logic DPRA1,
    input  logic DPRA2,
    input  logic DPRA3,
    input  logic DPRA4,
    input  logic DPRA5,
    output logic DPO
);

    logic mem [64];
    logic [5:0] waddr;
    logic [5:0] raddr;

    assign waddr = {A5, A4, A3, A2, A1, A0};
    assign raddr = {DPRA5, DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};

    always_ff @(posedge WCLK) begin
        if (WE)
            mem[waddr] <= D;
    end

    assign DPO = mem[raddr];

endmodule

module distram_sdp #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] wraddr,
    input  logic [WIDTH-1:0]     wrdata,
    input  logic                 wren,
    input  logic [ADDR_BITS-1:0] rdaddr,
    output logic [WIDTH-1:0]     rddata
);

    generate
        if (ADDR_BITS <= PRIM_ADDR_BITS) begin : g_prim
            // Unused upper address bits of each cell are tied low.
            logic [PRIM_ADDR_BITS-1:0] wa;
            logic [PRIM_ADDR_BITS-1:0] ra;

            assign wa = PRIM_ADDR_BITS'(wraddr);
            assign ra = PRIM_ADDR_BITS'(rdaddr);

            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                RAM64X1D u_cell (
                    .WCLK  (clk),
                    .WE    (wren),
                    .D     (wrdata[b]),
                    .A0    (wa[0]),
                    .A1    (wa[1]),
                    .A2    (wa[2]),
                    .A3    (wa[3]),
                    .A4    (wa[4]),
                    .A5    (wa[5]),
                    .DPRA0 (ra[0]),
                    .DPRA1 (ra[1]),
                    .DPRA2 (ra[2]),
                    .DPRA3 (ra[3]),
                    .DPRA4 (ra[4]),
                    .DPRA5 (ra[5]),
                    .DPO   (rddata[b])
                );
            end
        end else begin : g_infer
            logic [WIDTH-1:0] mem [2**ADDR_BITS];

            always_ff @(posedge clk) begin
                if (wren)
                    mem[wraddr] <= wrdata;
            end

            assign rddata = mem[rdaddr];
        end
    endgenerate

endmodule

// File: rtl/distram_fifo.sv
// First-word-fall-through FIFO on distributed RAM.
// State is just two wrap-around pointers; flags and occupancy derive from them.
import distram_fifo_pkg::*;

module distram_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int CNT_BITS = DEPTH_LOG2 + 1;
    localparam logic [CNT_BITS-1:0] DEPTH = CNT_BITS'(2**DEPTH_LOG2);

    logic [CNT_BITS-1:0] wr_ptr;
    logic [CNT_BITS-1:0] rd_ptr;
    logic                wr_ok;
    logic                rd_ok;

    // Extra pointer MSB separates a full ring from an empty one.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == DEPTH);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + CNT_BITS'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + CNT_BITS'(1);
        end
    end

    distram_sdp #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .wraddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wrdata (wr_data),
        .wren   (wr_ok && !flush),
        .rdaddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rddata (rd_data)
    );

endmodule
